fpu_norm_pipe: RTL and testbench

- Two-stage pipelined post-normalizer for the FPU datapath; it is the left-shift counterpart of the right-shift alignment path.
- Takes an unnormalized mantissa and a biased exponent, counts leading zeros, shifts the mantissa left and decrements the exponent.
- Handles zero and underflow/denormal outputs.
- Sits between the adder mantissa output and the rounder; uses a valid/ready handshake on both sides.

---
 rtl/fpu_norm_pipe.sv | 124 ++++++++++++
 tb/tb_fpu_norm_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_pipe.sv
// Two-stage post-normalizer: S1 captures the word with its leading-zero count,
// S2 applies the left shift, exponent adjustment and zero/underflow flags.
module fpu_norm_pipe #(
    parameter int WIDTH  = 32,
    parameter int SWIDTH = 5,
    parameter int EWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_mant,
    input  logic [EWIDTH-1:0] in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_mant,
    output logic [EWIDTH-1:0] out_exp,
    output logic              out_zero,
    output logic              out_uflow
);

    // Comparison width wide enough to hold either the exponent or the shift count.
    localparam int CW = ((EWIDTH > SWIDTH) ? EWIDTH : SWIDTH) + 1;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_mant;
    logic [EWIDTH-1:0] s1_exp;
    logic [SWIDTH-1:0] s1_lz;
    logic              s1_zero;

    logic              s2_valid;
    logic              s2_load;
    logic              in_fire;

    logic [SWIDTH-1:0] lz_next;
    logic [SWIDTH-1:0] sh;
    logic [CW-1:0]     lz_w;
    logic [CW-1:0]     exp_w;
    logic [WIDTH-1:0]  mant_next;
    logic [EWIDTH-1:0] exp_next;
    logic              zero_next;
    logic              uflow_next;

    // The highest set bit wins because later iterations overwrite earlier ones.
    function automatic logic [SWIDTH-1:0] count_lz(input logic [WIDTH-1:0] m);
        logic [SWIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) begin
                n = SWIDTH'(WIDTH - 1 - i);
            end
        end
        return n;
    endfunction

    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign lz_next   = count_lz(in_mant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_lz    <= '0;
            s1_zero  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_mant  <= in_mant;
                s1_exp   <= in_exp;
                s1_lz    <= lz_next;
                s1_zero  <= (in_mant == '0);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Underflow clamps the shift so the exponent lands exactly on zero (denormal).
    always_comb begin
        lz_w       = CW'(s1_lz);
        exp_w      = CW'(s1_exp);
        sh         = '0;
        exp_next   = '0;
        zero_next  = 1'b0;
        uflow_next = 1'b0;
        if (s1_zero) begin
            zero_next = 1'b1;
        end else if (lz_w < exp_w) begin
            sh       = s1_lz;
            exp_next = EWIDTH'(exp_w - lz_w);
        end else begin
            uflow_next = 1'b1;
            if (s1_exp != '0) begin
                sh = SWIDTH'(exp_w - CW'(1));
            end
        end
        mant_next = s1_zero ? '0 : (s1_mant << sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid  <= 1'b1;
                out_mant  <= mant_next;
                out_exp   <= exp_next;
                out_zero  <= zero_next;
                out_uflow <= uflow_next;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Directed bench for fpu_norm_pipe: single words, boundaries, backpressure and mid-stream reset.
module tb_fpu_norm_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_uflow;

    int checks   = 0;
    int failures = 0;

    fpu_norm_pipe #(.WIDTH(32), .SWIDTH(5), .EWIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference normalizer written as an explicit shift-until-MSB loop.
    task automatic refNorm(input logic [31:0] m, input logic [7:0] e,
                           output logic [31:0] rm, output logic [7:0] re,
                           output logic rz, output logic ru);
        int lz;
        int sh;
        logic [31:0] t;
        rm = 32'h0; re = 8'h0; rz = 1'b0; ru = 1'b0;
        if (m == 32'h0) begin
            rz = 1'b1;
        end else begin
            lz = 0;
            t  = m;
            while (t[31] == 1'b0) begin
                t  = t << 1;
                lz = lz + 1;
            end
            if (lz < int'(e)) begin
                rm = m << lz;
                re = 8'(int'(e) - lz);
            end else begin
                sh = (e == 8'd0) ? 0 : int'(e) - 1;
                rm = m << sh;
                ru = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] em, input logic [7:0] ee,
                               input logic ez, input logic eu);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".mant"},  out_mant, em);
        check({tag, ".exp"},   32'(out_exp), 32'(ee));
        check({tag, ".zero"},  32'(out_zero), 32'(ez));
        check({tag, ".uflow"}, 32'(out_uflow), 32'(eu));
    endtask

    // Sends one word with the output side open and checks the 2-edge latency.
    task automatic applyStimulus(input string tag, input logic [31:0] m, input logic [7:0] e,
                                 input logic [31:0] em, input logic [7:0] ee,
                                 input logic ez, input logic eu);
        @(negedge clk);
        in_valid = 1'b1; in_mant = m; in_exp = e; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput(tag, em, ee, ez, eu);
    endtask

    logic [31:0] vecMant [6];
    logic [7:0]  vecExp  [6];
    logic [31:0] rm;
    logic [7:0]  re;
    logic        rz;
    logic        ru;
    logic [31:0] heldMant;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_mant",  out_mant, 32'd0);
        check("reset.flags",     {30'd0, out_zero, out_uflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        applyStimulus("beef",    32'h0000BEEF, 8'd100, 32'hBEEF0000, 8'd84,  1'b0, 1'b0);
        applyStimulus("dead",    32'hDEADBEEF, 8'd5,   32'hDEADBEEF, 8'd5,   1'b0, 1'b0);
        applyStimulus("b8000",   32'h00008000, 8'd200, 32'h80000000, 8'd184, 1'b0, 1'b0);
        applyStimulus("uf10",    32'h00000001, 8'd10,  32'h00000200, 8'd0,   1'b0, 1'b1);
        applyStimulus("uf0",     32'h00000001, 8'd0,   32'h00000001, 8'd0,   1'b0, 1'b1);
        applyStimulus("zero",    32'h00000000, 8'd77,  32'h00000000, 8'd0,   1'b1, 1'b0);
        applyStimulus("lz_eq_e", 32'h00000001, 8'd31,  32'h40000000, 8'd0,   1'b0, 1'b1);
        applyStimulus("lz_lt_e", 32'h00000001, 8'd32,  32'h80000000, 8'd1,   1'b0, 1'b0);

        // Backpressure stream: out_ready low for the first 4 cycles.
        vecMant[0] = 32'h00F00000; vecExp[0] = 8'd50;
        vecMant[1] = 32'h00000003; vecExp[1] = 8'd3;
        vecMant[2] = 32'h00000000; vecExp[2] = 8'd9;
        vecMant[3] = 32'h7FFFFFFF; vecExp[3] = 8'd1;
        vecMant[4] = 32'h00010000; vecExp[4] = 8'd16;
        vecMant[5] = 32'h12345678; vecExp[5] = 8'd250;
        refNorm(vecMant[0], vecExp[0], rm, re, rz, ru);
        heldMant = rm;
        sent = 0; got = 0; cyc = 0;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (sent < 6);
            in_mant   = (sent < 6) ? vecMant[sent] : 32'h0;
            in_exp    = (sent < 6) ? vecExp[sent] : 8'h0;
            #1;
            if (cyc < 4) check($sformatf("bp.in_ready.c%0d", cyc), 32'(in_ready), 32'(sent < 2));
            if (cyc == 2 || cyc == 3) begin
                check($sformatf("bp.hold_valid.c%0d", cyc), 32'(out_valid), 32'd1);
                check($sformatf("bp.hold_mant.c%0d", cyc), out_mant, heldMant);
            end
            if (cyc == 4) check("bp.ready_restored", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (got < 6) begin
                    refNorm(vecMant[got], vecExp[got], rm, re, rz, ru);
                    checkOutput($sformatf("bp.word%0d", got), rm, re, rz, ru);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("bp.sent", 32'(sent), 32'd6);
        check("bp.got",  32'(got),  32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp.no_dup", 32'(out_valid), 32'd0);

        // Mid-stream reset with two words held.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_mant = 32'h00000001; in_exp = 8'd10;
        @(negedge clk);
        in_mant = 32'h00000100; in_exp = 8'd40;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst.pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_mant",  out_mant, 32'd0);
        check("rst.out_exp",   32'(out_exp), 32'd0);
        check("rst.flags",     {30'd0, out_zero, out_uflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.idle",     32'(out_valid), 32'd0);
        applyStimulus("post_rst", 32'h0000BEEF, 8'd100, 32'hBEEF0000, 8'd84, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
